pkt_dispatcher: RTL

// Ingress stage in front of the packet_buffer bank. Accepts one packet stream (bop/eop framed, 64-bit words plus
// 16-bit route tag) and steers each whole packet into an empty buffer, picked round-robin.

---
 rtl/pkt_dispatcher.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pkt_dispatcher.sv
// pkt_dispatcher
// Ingress stage for a bank of packet buffers. Takes one bop/eop framed stream
// and steers each whole packet into an empty buffer chosen round-robin.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   src_data/route/bop/eop/valid    source word stream; src_rdy back-pressure
//   buf_data, buf_route             shared word / route tag to all buffers
//   buf_req, buf_wr                 one-hot request and write strobe
//   buf_ack, buf_empty              per-buffer handshake and free status
//   pkt_cnt, drop_cnt, busy         statistics and FSM activity
module pkt_dispatcher #(
    parameter int NUM_BUF   = 4,
    parameter int MAX_WORDS = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [63:0]        src_data,
    input  logic [15:0]        src_route,
    input  logic               src_bop,
    input  logic               src_eop,
    input  logic               src_valid,
    output logic               src_rdy,
    output logic [63:0]        buf_data,
    output logic [15:0]        buf_route,
    output logic [NUM_BUF-1:0] buf_wr,
    output logic [NUM_BUF-1:0] buf_req,
    input  logic [NUM_BUF-1:0] buf_ack,
    input  logic [NUM_BUF-1:0] buf_empty,
    output logic [31:0]        pkt_cnt,
    output logic [15:0]        drop_cnt,
    output logic               busy
);
    localparam int SW = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] MAXW = CW'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      sel_q, sel_d, rr_q, rr_d, pick;
    logic               pick_ok;
    logic [NUM_BUF-1:0] req_q, req_d, wr_q, wr_d;
    logic [63:0]        data_q, data_d;
    logic [15:0]        route_q, route_d;
    logic [31:0]        pkt_q, pkt_d;
    logic [15:0]        drop_q, drop_d;
    logic [CW-1:0]      wcnt_q, wcnt_d;
    logic               drop_en, rdy;

    // First empty buffer at or after the RR pointer. Walking offsets from
    // high to low lets the smallest offset win.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % NUM_BUF;
            if (buf_empty[idx[SW-1:0]]) begin
                pick    = idx[SW-1:0];
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        req_d   = req_q;
        wr_d    = '0;
        data_d  = data_q;
        route_d = route_q;
        pkt_d   = pkt_q;
        wcnt_d  = wcnt_q;
        drop_en = 1'b0;
        rdy     = 1'b0;
        case (state_q)
            IDLE: begin
                // A bop word is held off until a buffer has been granted.
                rdy = !(src_valid && src_bop);
                if (src_valid && !src_bop) begin
                    drop_en = 1'b1;
                end else if (src_valid && src_bop && pick_ok) begin
                    sel_d   = pick;
                    req_d   = NUM_BUF'(1) << pick;
                    route_d = src_route;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (buf_ack[sel_q]) state_d = XFER;
            end
            XFER: begin
                rdy = 1'b1;
                if (src_valid) begin
                    // wcnt_q==0 marks the packet's own bop word; a later bop
                    // closes the packet and is itself discarded.
                    if (src_bop && wcnt_q != '0) begin
                        drop_en = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        if (wcnt_q < MAXW) begin
                            wr_d   = req_q;
                            data_d = src_data;
                            wcnt_d = wcnt_q + CW'(1);
                        end else begin
                            drop_en = 1'b1;
                        end
                        if (src_eop) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last registered write is on the bus this cycle, req still high.
                req_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!buf_ack[sel_q]) begin
                    pkt_d   = pkt_q + 32'd1;
                    rr_d    = (sel_q == SW'(NUM_BUF - 1)) ? '0 : sel_q + SW'(1);
                    wcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        drop_d = (drop_en && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            req_q   <= '0;
            wr_q    <= '0;
            data_q  <= '0;
            route_q <= '0;
            pkt_q   <= '0;
            drop_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            route_q <= route_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // src_rdy is combinational; gate it so it also reads 0 while in reset.
    assign src_rdy   = rdy & reset_n;
    assign buf_data  = data_q;
    assign buf_route = route_q;
    assign buf_wr    = wr_q;
    assign buf_req   = req_q;
    assign pkt_cnt   = pkt_q;
    assign drop_cnt  = drop_q;
    assign busy      = (state_q != IDLE);
endmodule
